// File: rtl/graphic_mixer.sv
// Priority pixel mixer for N_OBJS layers plus background, with per-frame
// player-car collision tracking and a saturating count of crash frames.
module graphic_mixer #(
   parameter int N_OBJS = 8,
   parameter int CW     = 1,
   parameter int CNT_W  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   video_on,
   input  logic                   frame_tick,
   input  logic [N_OBJS-1:0]      on_objs,
   input  logic [N_OBJS*3*CW-1:0] rgb_objs,
   input  logic [3*CW-1:0]        bg_rgb,
   input  logic                   cnt_clr,
   output logic [3*CW-1:0]        rgb,
   output logic                   rgb_valid,
   output logic [N_OBJS-1:0]      coll_live,
   output logic [N_OBJS-1:0]      coll_frame,
   output logic [CNT_W-1:0]       crash_cnt
);
   localparam int PW = 3*CW;

   logic [PW-1:0]     pix;
   logic [N_OBJS-1:0] hit;
   logic [N_OBJS-1:0] hit_all;

   // Ascending scan: later (higher-index) active layers overwrite earlier ones.
   always_comb begin
      pix = bg_rgb;
      for (int i = 0; i < N_OBJS; i++)
         if (on_objs[i]) pix = rgb_objs[i*PW +: PW];
   end

   // Object 0 is the player car, so it can never collide with itself.
   assign hit     = (video_on && on_objs[0]) ? {on_objs[N_OBJS-1:1], 1'b0} : '0;
   assign hit_all = coll_live | hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb        <= '0;
         rgb_valid  <= 1'b0;
         coll_live  <= '0;
         coll_frame <= '0;
         crash_cnt  <= '0;
      end else begin
         rgb       <= video_on ? pix : '0;
         rgb_valid <= video_on;
         if (frame_tick) begin
            coll_frame <= hit_all;
            coll_live  <= '0;
         end else begin
            coll_live  <= hit_all;
         end
         if (cnt_clr)
            crash_cnt <= '0;
         else if (frame_tick && (|hit_all) && (crash_cnt != {CNT_W{1'b1}}))
            crash_cnt <= crash_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_graphic_mixer.sv
// Directed and randomized checks of graphic_mixer against a cycle-level
// behavioural model (priority scan, collision sets, saturating frame count).
module tb_graphic_mixer;
   localparam int N     = 8;
   localparam int CW    = 1;
   localparam int PW    = 3*CW;
   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             video_on = 1'b0;
   logic             frame_tick = 1'b0;
   logic [N-1:0]     on_objs = '0;
   logic [N*PW-1:0]  rgb_objs = '0;
   logic [PW-1:0]    bg_rgb = '0;
   logic             cnt_clr = 1'b0;
   logic [PW-1:0]    rgb;
   logic             rgb_valid;
   logic [N-1:0]     coll_live;
   logic [N-1:0]     coll_frame;
   logic [CNT_W-1:0] crash_cnt;

   graphic_mixer #(.N_OBJS(N), .CW(CW), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .video_on(video_on), .frame_tick(frame_tick),
      .on_objs(on_objs), .rgb_objs(rgb_objs), .bg_rgb(bg_rgb), .cnt_clr(cnt_clr),
      .rgb(rgb), .rgb_valid(rgb_valid), .coll_live(coll_live),
      .coll_frame(coll_frame), .crash_cnt(crash_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference state
   int m_rgb, m_vld, m_live, m_frame, m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("rgb",        32'(rgb),        32'(m_rgb));
      chk("rgb_valid",  32'(rgb_valid),  32'(m_vld));
      chk("coll_live",  32'(coll_live),  32'(m_live));
      chk("coll_frame", 32'(coll_frame), 32'(m_frame));
      chk("crash_cnt",  32'(crash_cnt),  32'(m_cnt));
   endtask

   // Next-state of the reference from the inputs currently applied.
   task automatic model_step();
      int colls, frm;
      m_rgb = 0;
      if (video_on) begin
         m_rgb = int'(bg_rgb);
         for (int i = N-1; i >= 0; i--)
            if (on_objs[i]) begin
               m_rgb = (int'(rgb_objs) >> (i*PW)) & ((1 << PW) - 1);
               break;
            end
      end
      m_vld = video_on ? 1 : 0;
      colls = (video_on && on_objs[0]) ? (int'(on_objs) & ~1) : 0;
      if (frame_tick) begin
         frm     = m_live | colls;
         m_frame = frm;
         m_live  = 0;
         if (!cnt_clr && frm != 0 && m_cnt < CMAX) m_cnt++;
      end else begin
         m_live = m_live | colls;
      end
      if (cnt_clr) m_cnt = 0;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      chk_all();
   endtask

   task automatic idle_inputs();
      video_on = 1'b0; frame_tick = 1'b0; on_objs = '0; cnt_clr = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      m_rgb = 0; m_vld = 0; m_live = 0; m_frame = 0; m_cnt = 0;
      #1;
      chk_all();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [N*PW-1:0] objs;
      do_reset();

      // highest active index wins
      objs = '0;
      objs[2*PW +: PW] = 3'b010;
      objs[5*PW +: PW] = 3'b100;
      objs[0 +: PW]    = 3'b111;
      rgb_objs = objs; video_on = 1'b1; on_objs = 8'b0010_0101;
      step();
      chk("prio_obj5", 32'(rgb), 32'(3'b100));

      // background, then blanking
      do_reset();
      on_objs = '0; bg_rgb = 3'b001; video_on = 1'b1;
      step();
      chk("bg_rgb", 32'(rgb), 32'(3'b001));
      chk("bg_vld", 32'(rgb_valid), 32'(1));
      video_on = 1'b0; on_objs = 8'hff;
      step();
      chk("blank_rgb", 32'(rgb), 32'(0));
      chk("blank_vld", 32'(rgb_valid), 32'(0));

      // single collision with object 3, then tick
      do_reset();
      video_on = 1'b1; on_objs = 8'b0000_1001;
      step();
      on_objs = '0;
      step();
      chk("live_08", 32'(coll_live), 32'h08);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("frame_08", 32'(coll_frame), 32'h08);
      chk("live_clr", 32'(coll_live), 32'h00);
      chk("cnt_1", 32'(crash_cnt), 32'd1);

      // collision coincident with the tick
      do_reset();
      video_on = 1'b1; on_objs = 8'b0000_1001; frame_tick = 1'b1;
      step();
      idle_inputs();
      chk("same_tick_frame", 32'(coll_frame[3]), 32'd1);
      chk("same_tick_live", 32'(coll_live), 32'd0);
      chk("same_tick_cnt", 32'(crash_cnt), 32'd1);
      // back-to-back tick with no intervening collision
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("b2b_frame", 32'(coll_frame), 32'd0);

      // saturation at 3, then clear beats increment
      do_reset();
      for (int f = 1; f <= 5; f++) begin
         video_on = 1'b1; on_objs = 8'h81; frame_tick = 1'b0;
         step();
         on_objs = '0; frame_tick = 1'b1;
         step();
         chk("sat_seq", 32'(crash_cnt), 32'(f < 3 ? f : 3));
      end
      on_objs = 8'h81; frame_tick = 1'b1; cnt_clr = 1'b1;
      step();
      idle_inputs();
      chk("clr_prio", 32'(crash_cnt), 32'd0);

      // mid-frame reset discards pending collisions
      do_reset();
      video_on = 1'b1; on_objs = 8'h11;
      step();
      idle_inputs();
      chk("pre_rst_live", 32'(coll_live), 32'h10);
      reset = 1'b1;
      #1;
      chk("async_rgb", 32'(rgb), 32'd0);
      chk("async_live", 32'(coll_live), 32'd0);
      chk("async_vld", 32'(rgb_valid), 32'd0);
      m_rgb = 0; m_vld = 0; m_live = 0; m_frame = 0; m_cnt = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("post_rst_cnt", 32'(crash_cnt), 32'd0);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         video_on   = ($urandom_range(0, 7) != 0);
         on_objs    = N'($urandom);
         rgb_objs   = (N*PW)'($urandom);
         bg_rgb     = PW'($urandom);
         frame_tick = ($urandom_range(0, 7) == 0);
         cnt_clr    = ($urandom_range(0, 29) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/graphic_mixer.md
GRAPHIC_MIXER -- requirements
Module: graphic_mixer

Interface
REQ-001 Parameter N_OBJS, default 8: number of object layers, legal range 2..16.
REQ-002 Parameter CW, default 1: bits per colour channel; pixel width PW = 3*CW.
REQ-003 Parameter CNT_W, default 8: width of the collision-frame counter.
REQ-004 clk  in  1  system clock; all state SHALL change on the rising edge only.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 video_on  in  1  pixel is inside the visible area this cycle.
REQ-007 frame_tick  in  1  single-cycle pulse marking the start of a new frame.
REQ-008 on_objs  in  N_OBJS  per-object pixel-active flags; bit 0 is the player car.
REQ-009 rgb_objs  in  N_OBJS*PW  packed object colours, object i in bits [i*PW +: PW], channel order {b,g,r}.
REQ-010 bg_rgb  in  PW  background colour used when no object is active.
REQ-011 cnt_clr  in  1  synchronous clear of crash_cnt.
REQ-012 rgb  out  PW  registered mixed pixel.
REQ-013 rgb_valid  out  1  registered copy of video_on, aligned with rgb.
REQ-014 coll_live  out  N_OBJS  sticky per-object collision flags for the current frame; bit 0 is always 0.
REQ-015 coll_frame  out  N_OBJS  collision flags snapshotted from the previous frame.
REQ-016 crash_cnt  out  CNT_W  number of frames containing at least one collision, saturating.

Function
REQ-017 Winner selection SHALL be by fixed priority: the highest index i with on_objs[i]=1 wins.
REQ-018 If no bit of on_objs is set, the selected colour SHALL be bg_rgb.
REQ-019 Latency SHALL be exactly 1 clk: rgb and rgb_valid at cycle t+1 reflect the inputs at cycle t.
REQ-020 When video_on=0 at cycle t, rgb SHALL be all zeros at t+1, regardless of on_objs.
REQ-021 A collision at cycle t SHALL be defined as video_on=1, on_objs[0]=1 and on_objs[i]=1 for i>=1.
REQ-022 Each collision SHALL set coll_live[i] at t+1; set bits SHALL remain set until the next frame_tick.
REQ-023 On frame_tick, coll_frame SHALL load (coll_live OR collisions detected in that same cycle).
REQ-024 On frame_tick, coll_live SHALL clear to 0; a collision in the frame_tick cycle SHALL NOT carry into the new coll_live.
REQ-025 On frame_tick, crash_cnt SHALL increment by 1 if the loaded coll_frame value is nonzero.
REQ-026 crash_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-027 cnt_clr SHALL set crash_cnt to 0 on the next edge and has priority over a simultaneous increment.
REQ-028 frame_tick SHALL be honoured whether video_on is 0 or 1.
REQ-029 Back-to-back frame_tick pulses SHALL be legal; the second pulse loads a coll_frame containing only collisions from the intervening cycle.
REQ-030 Mixing and collision logic SHALL be fully parametric in N_OBJS and CW, with no per-object hand-written cases.

Reset
REQ-031 While reset=1, rgb, rgb_valid, coll_live, coll_frame and crash_cnt SHALL be 0, asynchronously.
REQ-032 Reset asserted mid-frame SHALL discard all pending collision flags; the first frame_tick after release SHALL load the flags collected since release.
REQ-033 The first rising clk edge after reset deasserts SHALL behave as a normal cycle, with no extra latency.

Verification
REQ-034 Stimulus: N_OBJS=8, CW=1, video_on=1, on_objs=8'b0010_0101, obj2=3'b010, obj5=3'b100. Required: rgb=3'b100 one cycle later.
REQ-035 Stimulus: on_objs=0, bg_rgb=3'b001, video_on toggling 1 then 0. Required: rgb=001 then 000, with rgb_valid=1 then 0, each one cycle delayed.
REQ-036 Stimulus: on_objs=8'b0000_1001 for one cycle, then frame_tick. Required: coll_live=8'h08 until the tick, then coll_frame=8'h08, coll_live=0, crash_cnt=1.
REQ-037 Stimulus: a collision with object 3 in the same cycle as frame_tick. Required: coll_frame[3]=1, coll_live=0 afterwards, crash_cnt incremented.
REQ-038 Stimulus: CNT_W=2, five frames each containing a collision, then cnt_clr together with a sixth colliding frame_tick. Required: crash_cnt sequence 1,2,3,3,3, then 0.
REQ-039 Stimulus: reset pulsed mid-frame after a collision. Required: all outputs 0 immediately; the next frame_tick with no further collisions leaves crash_cnt at 0.
